// File: rtl/gate_bist.sv
// Exhaustive BIST sequencer for a two-input combinational gate.
// Applies vectors 00,01,10,11 to the gate, holds each one for SETTLE+1 cycles,
// compares the gate output against a latched truth table, and reports the
// mismatch count, the first failing vector and an overall pass flag.
module gate_bist #(
  parameter int SETTLE = 1,
  parameter int ERR_W  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       truth,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_r,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0]       SETTLE_C = 4'(SETTLE);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           state_reg;
  logic [1:0]       vec_reg;
  logic [3:0]       cnt_reg;
  logic [3:0]       truth_reg;
  logic             cmp_now;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  // Compare strobe, mismatch detect and saturating error count candidate.
  always_comb begin
    cmp_now  = (state_reg == RUN) && (cnt_reg == SETTLE_C);
    mismatch = cmp_now && (dut_r != truth_reg[vec_reg]);
    err_next = err_count;
    if (mismatch && (err_count != ERR_MAX)) begin
      err_next = err_count + 1'b1;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      vec_reg    <= 2'd0;
      cnt_reg    <= 4'd0;
      truth_reg  <= 4'd0;
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= 2'd0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          // done is a single-cycle pulse; a start here may restart at once.
          done <= 1'b0;
          if (start) begin
            state_reg  <= RUN;
            vec_reg    <= 2'd0;
            cnt_reg    <= 4'd0;
            truth_reg  <= truth;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            busy       <= 1'b1;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= 2'd0;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          // start is deliberately not looked at here: no restart mid-run.
          if (cmp_now) begin
            cnt_reg   <= 4'd0;
            err_count <= err_next;
            if (mismatch && !fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= vec_reg;
            end
            if (vec_reg == 2'd3) begin
              state_reg <= DONE;
              vec_reg   <= 2'd0;
              dut_a     <= 1'b0;
              dut_b     <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              pass      <= (err_next == '0);
            end else begin
              vec_reg        <= vec_reg + 2'd1;
              {dut_a, dut_b} <= vec_reg + 2'd1;
            end
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gate_bist.md
GATE_BIST -- requirements
Module: gate_bist

Interface
REQ-001 Parameter: SETTLE, default 1, number of extra cycles each vector is held before the DUT output is compared; legal range 0..15.
REQ-002 Parameter: ERR_W, default 3, width of the mismatch counter.
REQ-003 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  synchronous, active-low reset.
REQ-005 Port: start  input  1  request an exhaustive test run, sampled in IDLE/DONE only.
REQ-006 Port: truth  input  4  expected DUT output per vector: truth[v] for vector v; sampled on the start-accept edge.
REQ-007 Port: dut_a  output  1  DUT input a, equals vec[1].
REQ-008 Port: dut_b  output  1  DUT input b, equals vec[0].
REQ-009 Port: dut_r  input  1  DUT output, treated as combinational from dut_a/dut_b.
REQ-010 Port: busy  output  1  high while a run is in progress.
REQ-011 Port: done  output  1  one-cycle pulse when a run completes.
REQ-012 Port: pass  output  1  high when the last completed run had zero mismatches.
REQ-013 Port: err_count  output  ERR_W  mismatches in the current/last run.
REQ-014 Port: fail_valid  output  1  high once a mismatch has been recorded in the current/last run.
REQ-015 Port: fail_vec  output  2  vector index {a,b} of the first mismatch.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-017 In IDLE or DONE, start=1 at an edge SHALL: enter RUN, set vec=0, hold cnt=0, latch truth, and clear err_count, fail_valid, fail_vec, pass.
REQ-018 start SHALL be ignored while busy=1; no restart, no state change.
REQ-019 Vector order SHALL be 00, 01, 10, 11 as {dut_a,dut_b}; dut_a/dut_b are registered outputs driven from vec during RUN and are 0 in IDLE/DONE.
REQ-020 Each vector SHALL be held for SETTLE+1 cycles; cnt increments each RUN cycle, and the compare occurs on the edge where cnt==SETTLE, after which cnt=0 and vec increments.
REQ-021 Compare SHALL flag a mismatch when dut_r != latched truth[vec].
REQ-022 On a mismatch, err_count SHALL increment, saturating at 2^ERR_W-1 with no wrap.
REQ-023 On the first mismatch of a run, fail_vec SHALL capture vec and fail_valid SHALL be set; later mismatches SHALL NOT overwrite fail_vec.
REQ-024 The compare edge of vector 3 SHALL move the FSM to DONE: busy=0, done=1, pass=(final err_count==0), with the vector-3 result included.
REQ-025 Latency: from the start-accept edge E0, done SHALL be high in the cycle after edge E0+4*(SETTLE+1); this is 8 cycles for SETTLE=1.
REQ-026 Results (pass, err_count, fail_valid, fail_vec) SHALL hold until the next accepted start or reset.
REQ-027 start=1 while done=1 SHALL be accepted; done falls and busy rises on that same edge.
REQ-028 Changes to truth during RUN SHALL have no effect.

Reset
REQ-029 rst_n=0 at an edge SHALL force IDLE, vec=0, cnt=0, dut_a=0, dut_b=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, regardless of state.
REQ-030 Reset mid-run SHALL abort without a done pulse; the first post-reset start SHALL begin a fresh run from vector 00.

Verification
REQ-031 Correct NAND DUT, truth=4'b0111, SETTLE=1: start pulse -> {a,b} sequence 00,01,10,11, each held 2 cycles; done at cycle 8; pass=1, err_count=0, fail_valid=0.
REQ-032 AND DUT with truth=4'b0111 (NAND expected) -> all 4 vectors mismatch: err_count=4, fail_vec=00, fail_valid=1, pass=0.
REQ-033 ERR_W=2, constant-0 DUT, truth=4'b1111 -> err_count saturates at 3; fail_vec=00; pass=0.
REQ-034 Second start pulse mid-run, then truth changed mid-run -> no restart; done still at cycle 8; results use the originally latched truth.
REQ-035 rst_n=0 asserted during vector 10 -> next edge: all outputs 0, no done; new start -> full run with done 8 cycles later.
REQ-036 SETTLE=0, start held high continuously -> back-to-back runs: done every 5 cycles and restarted on the same edge as done, with results cleared at each restart.
